// File: rtl/snitch_icache_pkg.sv
// Shared instruction-cache definitions: tag-entry layout and controller states.
package snitch_icache_pkg;

    typedef enum logic {
        SWEEP,
        IDLE
    } tag_state_e;

    // Stored entry is {valid, error, tag}.
    localparam int unsigned TAG_META_BITS = 2;

    function automatic int unsigned valid_bit(input int unsigned tag_width);
        return tag_width + 1;
    endfunction

    function automatic int unsigned error_bit(input int unsigned tag_width);
        return tag_width;
    endfunction

    function automatic int unsigned set_align(input int unsigned set_count);
        return (set_count > 1) ? $clog2(set_count) : 1;
    endfunction

endpackage

// File: rtl/snitch_icache_victim_sel.sv
// Victim way selection: lowest invalid way, otherwise a round-robin pointer.
module snitch_icache_victim_sel
    import snitch_icache_pkg::*;
#(
    parameter int unsigned SET_COUNT = 2,
    parameter int unsigned SET_ALIGN = set_align(SET_COUNT)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [SET_COUNT-1:0] valid_i,
    input  logic                 advance_i,
    output logic [SET_ALIGN-1:0] victim_o
);

    logic [SET_ALIGN-1:0] ptr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= (ptr_q == SET_ALIGN'(SET_COUNT - 1)) ? '0 : ptr_q + SET_ALIGN'(1);
        end
    end

    always_comb begin
        logic found;
        found    = 1'b0;
        victim_o = ptr_q;
        for (int unsigned i = 0; i < SET_COUNT; i++) begin
            if (!valid_i[i] && !found) begin
                victim_o = SET_ALIGN'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snitch_icache_tag_ctrl.sv
// Tag memory sequencer: init/flush sweeps, refill writes and lookups with
// fixed priority, plus a one-cycle-latency hit/miss response.
module snitch_icache_tag_ctrl
    import snitch_icache_pkg::*;
#(
    parameter int unsigned SET_COUNT   = 2,
    parameter int unsigned LINE_COUNT  = 128,
    parameter int unsigned TAG_WIDTH   = 37,
    parameter int unsigned COUNT_ALIGN = $clog2(LINE_COUNT),
    parameter int unsigned SET_ALIGN   = set_align(SET_COUNT),
    parameter int unsigned ENTRY_WIDTH = TAG_WIDTH + TAG_META_BITS
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_valid_i,
    output logic                             flush_ready_o,
    output logic                             flush_done_o,
    output logic                             busy_o,
    input  logic                             write_valid_i,
    output logic                             write_ready_o,
    input  logic [COUNT_ALIGN-1:0]           write_addr_i,
    input  logic [SET_ALIGN-1:0]             write_set_i,
    input  logic [TAG_WIDTH-1:0]             write_tag_i,
    input  logic                             write_error_i,
    input  logic                             lookup_valid_i,
    output logic                             lookup_ready_o,
    input  logic [COUNT_ALIGN-1:0]           lookup_addr_i,
    input  logic [TAG_WIDTH-1:0]             lookup_tag_i,
    output logic                             rsp_valid_o,
    output logic                             rsp_hit_o,
    output logic                             rsp_error_o,
    output logic [SET_ALIGN-1:0]             rsp_set_o,
    output logic [SET_COUNT-1:0]             ram_enable_o,
    output logic                             ram_write_o,
    output logic [COUNT_ALIGN-1:0]           ram_addr_o,
    output logic [SET_COUNT*ENTRY_WIDTH-1:0] ram_wtag_o,
    input  logic [SET_COUNT*ENTRY_WIDTH-1:0] ram_rtag_i
);

    localparam int unsigned VALID_BIT = valid_bit(TAG_WIDTH);
    localparam int unsigned ERROR_BIT = error_bit(TAG_WIDTH);

    tag_state_e             state_q, state_d;
    logic [COUNT_ALIGN-1:0] cnt_q, cnt_d;
    logic                   sweep_last;
    logic                   lookup_fire;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [SET_COUNT-1:0]   way_valid;
    logic [SET_ALIGN-1:0]   victim;

    assign busy_o = (state_q == SWEEP);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= SWEEP;
            cnt_q        <= '0;
            flush_done_o <= 1'b0;
            rsp_valid_o  <= 1'b0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_done_o <= sweep_last;
            rsp_valid_o  <= lookup_fire;
            if (lookup_fire) begin
                tag_q <= lookup_tag_i;
            end
        end
    end

    // Outputs are gated by rst_ni so the SRAMs see no requests while reset is held.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sweep_last     = 1'b0;
        lookup_fire    = 1'b0;
        flush_ready_o  = 1'b0;
        write_ready_o  = 1'b0;
        lookup_ready_o = 1'b0;
        ram_enable_o   = '0;
        ram_write_o    = 1'b0;
        ram_addr_o     = '0;
        ram_wtag_o     = '0;
        if (rst_ni) begin
            unique case (state_q)
                SWEEP: begin
                    ram_enable_o = '1;
                    ram_write_o  = 1'b1;
                    ram_addr_o   = cnt_q;
                    if (cnt_q == COUNT_ALIGN'(LINE_COUNT - 1)) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        sweep_last = 1'b1;
                    end else begin
                        cnt_d = cnt_q + COUNT_ALIGN'(1);
                    end
                end
                IDLE: begin
                    flush_ready_o  = 1'b1;
                    write_ready_o  = !flush_valid_i;
                    lookup_ready_o = !flush_valid_i && !write_valid_i;
                    if (flush_valid_i) begin
                        // Accept cycle clears line 0; the sweep continues from line 1.
                        ram_enable_o = '1;
                        ram_write_o  = 1'b1;
                        state_d      = SWEEP;
                        cnt_d        = COUNT_ALIGN'(1);
                    end else if (write_valid_i) begin
                        ram_enable_o = SET_COUNT'(1) << write_set_i;
                        ram_write_o  = 1'b1;
                        ram_addr_o   = write_addr_i;
                        ram_wtag_o[write_set_i*ENTRY_WIDTH +: ENTRY_WIDTH] =
                            {1'b1, write_error_i, write_tag_i};
                    end else if (lookup_valid_i) begin
                        ram_enable_o = '1;
                        ram_addr_o   = lookup_addr_i;
                        lookup_fire  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Lowest-index matching way wins when several ways hit.
    always_comb begin
        logic [ENTRY_WIDTH-1:0] entry;
        entry       = '0;
        way_valid   = '0;
        rsp_hit_o   = 1'b0;
        rsp_error_o = 1'b0;
        rsp_set_o   = victim;
        for (int unsigned i = 0; i < SET_COUNT; i++) begin
            entry        = ram_rtag_i[i*ENTRY_WIDTH +: ENTRY_WIDTH];
            way_valid[i] = entry[VALID_BIT];
            if (entry[VALID_BIT] && (entry[TAG_WIDTH-1:0] == tag_q) && !rsp_hit_o) begin
                rsp_hit_o   = 1'b1;
                rsp_error_o = entry[ERROR_BIT];
                rsp_set_o   = SET_ALIGN'(i);
            end
        end
    end

    snitch_icache_victim_sel #(
        .SET_COUNT (SET_COUNT),
        .SET_ALIGN (SET_ALIGN)
    ) i_victim_sel (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (way_valid),
        .advance_i (rsp_valid_o && !rsp_hit_o && (&way_valid)),
        .victim_o  (victim)
    );

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// Self-checking bench: behavioural SRAM plus a line-level reference model of the tag store.
module tb_snitch_icache_tag_ctrl;

    localparam int unsigned SC = 2;
    localparam int unsigned LC = 128;
    localparam int unsigned TW = 37;
    localparam int unsigned CA = 7;
    localparam int unsigned SA = 1;
    localparam int unsigned EW = TW + 2;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              flush_valid = 1'b0, flush_ready, flush_done, busy;
    logic              write_valid = 1'b0, write_ready;
    logic [CA-1:0]     write_addr = '0;
    logic [SA-1:0]     write_set = '0;
    logic [TW-1:0]     write_tag = '0;
    logic              write_error = 1'b0;
    logic              lookup_valid = 1'b0, lookup_ready;
    logic [CA-1:0]     lookup_addr = '0;
    logic [TW-1:0]     lookup_tag = '0;
    logic              rsp_valid, rsp_hit, rsp_error;
    logic [SA-1:0]     rsp_set;
    logic [SC-1:0]     ram_enable;
    logic              ram_write;
    logic [CA-1:0]     ram_addr;
    logic [SC*EW-1:0]  ram_wtag;
    logic [SC*EW-1:0]  ram_rtag = '0;

    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    snitch_icache_tag_ctrl #(
        .SET_COUNT  (SC),
        .LINE_COUNT (LC),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_valid_i  (flush_valid),
        .flush_ready_o  (flush_ready),
        .flush_done_o   (flush_done),
        .busy_o         (busy),
        .write_valid_i  (write_valid),
        .write_ready_o  (write_ready),
        .write_addr_i   (write_addr),
        .write_set_i    (write_set),
        .write_tag_i    (write_tag),
        .write_error_i  (write_error),
        .lookup_valid_i (lookup_valid),
        .lookup_ready_o (lookup_ready),
        .lookup_addr_i  (lookup_addr),
        .lookup_tag_i   (lookup_tag),
        .rsp_valid_o    (rsp_valid),
        .rsp_hit_o      (rsp_hit),
        .rsp_error_o    (rsp_error),
        .rsp_set_o      (rsp_set),
        .ram_enable_o   (ram_enable),
        .ram_write_o    (ram_write),
        .ram_addr_o     (ram_addr),
        .ram_wtag_o     (ram_wtag),
        .ram_rtag_i     (ram_rtag)
    );

    // Single-port SRAMs, one-cycle read latency.
    logic [EW-1:0] mem [SC][LC];
    always @(posedge clk) begin
        for (int w = 0; w < SC; w++) begin
            if (ram_enable[w]) begin
                if (ram_write) mem[w][ram_addr] <= ram_wtag[w*EW +: EW];
                else           ram_rtag[w*EW +: EW] <= mem[w][ram_addr];
            end
        end
    end

    // Reference model state.
    bit          m_valid [SC][LC];
    bit          m_err   [SC][LC];
    logic [TW-1:0] m_tag [SC][LC];
    int unsigned left = LC;
    int unsigned rr = 0;
    bit          exp_done = 0;
    bit          exp_pend = 0;
    bit          exp_hit, exp_err;
    int unsigned exp_set;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_lookup(input int unsigned a, input logic [TW-1:0] t);
        bit allv;
        bit found;
        exp_hit = 0; exp_err = 0; exp_set = 0;
        for (int w = 0; w < SC; w++) begin
            if (m_valid[w][a] && m_tag[w][a] == t && !exp_hit) begin
                exp_hit = 1; exp_set = w; exp_err = m_err[w][a];
            end
        end
        if (!exp_hit) begin
            allv = 1; found = 0; exp_set = rr;
            for (int w = 0; w < SC; w++) begin
                if (!m_valid[w][a]) begin
                    allv = 0;
                    if (!found) begin exp_set = w; found = 1; end
                end
            end
            if (allv) rr = (rr + 1) % SC;
        end
    endtask

    task automatic cyc(input bit fv, input bit wv, input int unsigned wa, input int unsigned ws,
                       input logic [TW-1:0] wt, input bit we,
                       input bit lv, input int unsigned la, input logic [TW-1:0] lt);
        @(negedge clk);
        chk("rsp_valid", 128'(rsp_valid), 128'(exp_pend));
        if (exp_pend) begin
            chk("rsp_hit", 128'(rsp_hit), 128'(exp_hit));
            chk("rsp_set", 128'(rsp_set), 128'(exp_set));
            chk("rsp_error", 128'(rsp_error), 128'(exp_err));
        end
        chk("flush_done", 128'(flush_done), 128'(exp_done));
        rst_ni = 1'b1;
        flush_valid = fv; write_valid = wv; lookup_valid = lv;
        write_addr = CA'(wa); write_set = SA'(ws); write_tag = wt; write_error = we;
        lookup_addr = CA'(la); lookup_tag = lt;
        #1;
        exp_done = 0; exp_pend = 0;
        if (left > 0) begin
            chk("sweep_busy", 128'(busy), 128'(1));
            chk("sweep_readys", 128'({flush_ready, write_ready, lookup_ready}), 128'(0));
            chk("sweep_en", 128'(ram_enable), 128'({SC{1'b1}}));
            chk("sweep_we", 128'(ram_write), 128'(1));
            chk("sweep_addr", 128'(ram_addr), 128'(LC - left));
            chk("sweep_data", 128'(ram_wtag), 128'(0));
            left--;
            if (left == 0) exp_done = 1;
        end else begin
            chk("idle_busy", 128'(busy), 128'(0));
            chk("readys", 128'({flush_ready, write_ready, lookup_ready}),
                128'({1'b1, !fv, !fv && !wv}));
            if (fv) begin
                chk("flush_en", 128'(ram_enable), 128'({SC{1'b1}}));
                chk("flush_we", 128'(ram_write), 128'(1));
                chk("flush_addr", 128'(ram_addr), 128'(0));
                chk("flush_data", 128'(ram_wtag), 128'(0));
                for (int w = 0; w < SC; w++)
                    for (int l = 0; l < LC; l++) m_valid[w][l] = 0;
                left = LC - 1;
            end else if (wv) begin
                chk("write_en", 128'(ram_enable), 128'(1 << ws));
                chk("write_we", 128'(ram_write), 128'(1));
                chk("write_addr", 128'(ram_addr), 128'(wa));
                chk("write_data", 128'(ram_wtag[ws*EW +: EW]), 128'({1'b1, we, wt}));
                m_valid[ws][wa] = 1; m_err[ws][wa] = we; m_tag[ws][wa] = wt;
            end else if (lv) begin
                chk("lookup_en", 128'(ram_enable), 128'({SC{1'b1}}));
                chk("lookup_we", 128'(ram_write), 128'(0));
                chk("lookup_addr", 128'(ram_addr), 128'(la));
                model_lookup(la, lt);
                exp_pend = 1;
            end else begin
                chk("idle_en", 128'({ram_enable, ram_write}), 128'(0));
                chk("idle_bus", 128'({ram_addr, ram_wtag}), 128'(0));
            end
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) cyc(0, 0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic wr(input int unsigned a, input int unsigned s, input logic [TW-1:0] t, input bit e);
        cyc(0, 1, a, s, t, e, 0, 0, '0);
    endtask

    task automatic lk(input int unsigned a, input logic [TW-1:0] t);
        cyc(0, 0, 0, 0, '0, 0, 1, a, t);
    endtask

    task automatic reset_pulse(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
                chk("rst_flush_done", 128'(flush_done), 128'(0));
                chk("rst_busy", 128'(busy), 128'(1));
            end
            rst_ni = 1'b0;
            lookup_valid = 1'b1;
            #1;
            chk("rst_readys", 128'({flush_ready, write_ready, lookup_ready}), 128'(0));
            chk("rst_ram", 128'({ram_enable, ram_write, ram_addr, ram_wtag}), 128'(0));
        end
        lookup_valid = 1'b0;
        left = LC; rr = 0; exp_pend = 0; exp_done = 0;
    endtask

    initial begin
        reset_pulse(3);
        idle(LC + 1);
        lk(3, 37'h5);
        idle(1);

        wr(10, 1, 37'hABC, 0);
        lk(10, 37'hABC);
        lk(10, 37'hABD);
        idle(1);

        wr(4, 0, 37'h11, 1);
        wr(4, 1, 37'h22, 0);
        lk(4, 37'h33);
        lk(4, 37'h11);
        lk(4, 37'h33);
        lk(4, 37'h33);
        lk(4, 37'h22);
        idle(1);

        cyc(1, 1, 5, 0, 37'h77, 0, 1, 5, 37'h77);
        for (int k = 0; k < LC - 1; k++) cyc(0, 1, 5, 0, 37'h77, 0, 1, 5, 37'h77);
        cyc(0, 1, 5, 0, 37'h77, 0, 1, 5, 37'h77);
        lk(5, 37'h77);
        idle(1);

        cyc(0, 1, 6, 1, 37'h66, 1, 1, 6, 37'h66);
        for (int k = 0; k < 4; k++) lk(6, (k % 2 == 0) ? 37'h66 : 37'h65);
        idle(2);

        for (int k = 0; k < 400; k++) begin
            cyc(($urandom % 96) == 0, ($urandom % 3) == 0, $urandom % 8, $urandom % SC,
                TW'($urandom_range(1, 4)), $urandom % 2,
                ($urandom % 2) == 0, $urandom % 8, TW'($urandom_range(1, 4)));
        end
        while (left > 0) idle(1);
        idle(1);

        cyc(1, 0, 0, 0, '0, 0, 0, 0, '0);
        while (left != LC - 60) idle(1);
        reset_pulse(1);
        idle(LC + 1);

        wr(2, 0, 37'h1, 0);
        wr(2, 1, 37'h2, 0);
        lk(2, 37'h3);
        lk(2, 37'h3);
        cyc(0, 0, 0, 0, '0, 0, 1, 2, 37'h3);
        reset_pulse(2);
        idle(LC + 1);
        wr(2, 0, 37'h1, 0);
        wr(2, 1, 37'h2, 0);
        lk(2, 37'h3);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
